imem_boot_loader: RTL and testbench

IMEM_BOOT_LOADER -- requirements
Module: imem_boot_loader

---
 rtl/imem_boot_loader.sv | 145 ++++++++++++++
 tb/tb_imem_boot_loader.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_boot_loader.sv
// rtl/imem_boot_loader.sv - boot-stream byte loader writing 32-bit words into instruction memory.
// Optional trailing 32-bit checksum enabled by macro LOADER_CHECKSUM_EN.
module imem_boot_loader #(
   parameter int IM_AW = 7
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [7:0]       in_data,
   output logic             in_ready,
   output logic             im_we,
   output logic [IM_AW-1:0] im_addr,
   output logic [31:0]      im_wdata,
   output logic             cpu_rstn,
   output logic             done,
   output logic             err,
   output logic [15:0]      words_loaded
);

`ifdef LOADER_CHECKSUM_EN
   typedef enum logic [2:0] {HDR0, HDR1, DATA, CSUM, DONE, ERR} state_t;
   logic [31:0] csum;
`else
   typedef enum logic [2:0] {HDR0, HDR1, DATA, DONE, ERR} state_t;
`endif

   localparam logic [16:0] CAPACITY = 17'd1 << IM_AW;

   state_t      state;
   logic [7:0]  hdr_lo;
   logic [15:0] n_words;
   logic [1:0]  byte_cnt;
   logic [23:0] asm_q;
   logic        accept;
   logic [31:0] word;

   assign accept = in_valid && in_ready;
   assign word   = {in_data, asm_q};

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= HDR0;
         in_ready     <= 1'b1;
         done         <= 1'b0;
         err          <= 1'b0;
         cpu_rstn     <= 1'b0;
         im_we        <= 1'b0;
         im_addr      <= '0;
         im_wdata     <= '0;
         words_loaded <= '0;
         hdr_lo       <= '0;
         n_words      <= '0;
         byte_cnt     <= '0;
         asm_q        <= '0;
`ifdef LOADER_CHECKSUM_EN
         csum         <= '0;
`endif
      end else begin
         im_we <= 1'b0;
         case (state)
            HDR0: begin
               if (accept) begin
                  hdr_lo <= in_data;
                  state  <= HDR1;
               end
            end
            HDR1: begin
               if (accept) begin
                  n_words <= {in_data, hdr_lo};
                  if ({in_data, hdr_lo} == 16'd0) begin
`ifdef LOADER_CHECKSUM_EN
                     state <= CSUM;
`else
                     state    <= DONE;
                     in_ready <= 1'b0;
                     done     <= 1'b1;
`endif
                  end else if ({1'b0, in_data, hdr_lo} > CAPACITY) begin
                     state    <= ERR;
                     in_ready <= 1'b0;
                     err      <= 1'b1;
                  end else begin
                     state <= DATA;
                  end
               end
            end
            DATA: begin
               if (accept) begin
                  byte_cnt <= byte_cnt + 2'd1;
                  asm_q    <= {in_data, asm_q[23:8]};
                  if (byte_cnt == 2'd3) begin
                     // words_loaded doubles as the index of the word being completed
                     im_we        <= 1'b1;
                     im_addr      <= words_loaded[IM_AW-1:0];
                     im_wdata     <= word;
                     words_loaded <= words_loaded + 16'd1;
`ifdef LOADER_CHECKSUM_EN
                     csum <= csum + word;
                     if (words_loaded + 16'd1 == n_words) begin
                        state <= CSUM;
                     end
`else
                     if (words_loaded + 16'd1 == n_words) begin
                        state    <= DONE;
                        in_ready <= 1'b0;
                        done     <= 1'b1;
                     end
`endif
                  end
               end
            end
`ifdef LOADER_CHECKSUM_EN
            CSUM: begin
               if (accept) begin
                  byte_cnt <= byte_cnt + 2'd1;
                  asm_q    <= {in_data, asm_q[23:8]};
                  if (byte_cnt == 2'd3) begin
                     in_ready <= 1'b0;
                     if (word == csum) begin
                        state <= DONE;
                        done  <= 1'b1;
                     end else begin
                        state <= ERR;
                        err   <= 1'b1;
                     end
                  end
               end
            end
`endif
            DONE: begin
               cpu_rstn <= 1'b1;
            end
            ERR: begin
               cpu_rstn <= 1'b0;
            end
            default: begin
               state    <= ERR;
               in_ready <= 1'b0;
               err      <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_imem_boot_loader.sv
// tb/tb_imem_boot_loader.sv - table-driven bench for imem_boot_loader plus a gapped-stream sequence.
module tb_imem_boot_loader;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic [7:0]  in_data;
   logic        in_ready;
   logic        im_we;
   logic [6:0]  im_addr;
   logic [31:0] im_wdata;
   logic        cpu_rstn;
   logic        done;
   logic        err;
   logic [15:0] words_loaded;

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   imem_boot_loader #(.IM_AW(7)) dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .in_data      (in_data),
      .in_ready     (in_ready),
      .im_we        (im_we),
      .im_addr      (im_addr),
      .im_wdata     (im_wdata),
      .cpu_rstn     (cpu_rstn),
      .done         (done),
      .err          (err),
      .words_loaded (words_loaded)
   );

   typedef struct {
      logic        r;
      logic        v;
      logic [7:0]  d;
      logic [59:0] e;
   } vec_t;

   vec_t vq[$];

   function automatic logic [59:0] ex(logic rdy, logic we, logic [6:0] a, logic [31:0] wd,
                                      logic rs, logic dn, logic er, logic [15:0] wl);
      return {rdy, we, a, wd, rs, dn, er, wl};
   endfunction

   function automatic logic [59:0] z();
      return ex(1'b1, 1'b0, 7'd0, 32'd0, 1'b0, 1'b0, 1'b0, 16'd0);
   endfunction

   task automatic ap(input logic r, input logic v, input logic [7:0] d, input logic [59:0] e);
      vq.push_back('{r: r, v: v, d: d, e: e});
   endtask

   task automatic rs_v();
      ap(1'b1, 1'b1, 8'hA5, z());
   endtask

   // one accepted byte followed by one idle cycle
   task automatic ap2(input logic [7:0] d, input logic rdy, input logic we, input logic [6:0] a,
                      input logic [31:0] wd, input logic dn, input logic [15:0] wl);
      ap(1'b0, 1'b1, d, ex(rdy, we, a, wd, 1'b0, dn, 1'b0, wl));
      ap(1'b0, 1'b0, 8'hFF, ex(rdy, 1'b0, a, wd, dn, dn, 1'b0, wl));
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   logic [59:0] e_err;
   logic [7:0]  hs[$];
   logic [31:0] hw[3];
   int          idx;
   int          nw;
   logic        acc;
   logic        got_done;

   initial begin
      rst      = 1'b1;
      in_valid = 1'b0;
      in_data  = 8'h00;
      e_err    = ex(1'b0, 1'b0, 7'd0, 32'd0, 1'b0, 1'b0, 1'b1, 16'd0);

      // header 0x0081 exceeds 128-word capacity
      rs_v();
      ap(1'b0, 1'b1, 8'h81, z());
      ap(1'b0, 1'b1, 8'h00, e_err);
      ap(1'b0, 1'b1, 8'h12, e_err);
      ap(1'b0, 1'b0, 8'h00, e_err);
      // high-byte-only header 0x0100
      rs_v();
      ap(1'b0, 1'b1, 8'h00, z());
      ap(1'b0, 1'b1, 8'h01, e_err);
      // header exactly at capacity 0x0080 is accepted
      rs_v();
      ap(1'b0, 1'b1, 8'h80, z());
      ap(1'b0, 1'b1, 8'h00, z());
      ap(1'b0, 1'b1, 8'h01, z());
      ap(1'b0, 1'b1, 8'h00, z());
      ap(1'b0, 1'b1, 8'h00, z());
      ap(1'b0, 1'b1, 8'h00, ex(1, 1, 7'd0, 32'h1, 0, 0, 0, 16'd1));

`ifndef LOADER_CHECKSUM_EN
      // two words, in_valid held high, then extra bytes after done
      rs_v();
      ap(0, 1, 8'h02, z());
      ap(0, 1, 8'h00, z());
      ap(0, 1, 8'h05, z());
      ap(0, 1, 8'h00, z());
      ap(0, 1, 8'h08, z());
      ap(0, 1, 8'h20, ex(1, 1, 7'd0, 32'h20080005, 0, 0, 0, 16'd1));
      ap(0, 1, 8'h20, ex(1, 0, 7'd0, 32'h20080005, 0, 0, 0, 16'd1));
      ap(0, 1, 8'h48, ex(1, 0, 7'd0, 32'h20080005, 0, 0, 0, 16'd1));
      ap(0, 1, 8'h09, ex(1, 0, 7'd0, 32'h20080005, 0, 0, 0, 16'd1));
      ap(0, 1, 8'h01, ex(0, 1, 7'd1, 32'h01094820, 0, 1, 0, 16'd2));
      ap(0, 1, 8'h55, ex(0, 0, 7'd1, 32'h01094820, 1, 1, 0, 16'd2));
      ap(0, 1, 8'h66, ex(0, 0, 7'd1, 32'h01094820, 1, 1, 0, 16'd2));
      // same stream with in_valid toggling
      rs_v();
      ap2(8'h02, 1, 0, 7'd0, 32'h0, 0, 16'd0);
      ap2(8'h00, 1, 0, 7'd0, 32'h0, 0, 16'd0);
      ap2(8'h05, 1, 0, 7'd0, 32'h0, 0, 16'd0);
      ap2(8'h00, 1, 0, 7'd0, 32'h0, 0, 16'd0);
      ap2(8'h08, 1, 0, 7'd0, 32'h0, 0, 16'd0);
      ap2(8'h20, 1, 1, 7'd0, 32'h20080005, 0, 16'd1);
      ap2(8'h20, 1, 0, 7'd0, 32'h20080005, 0, 16'd1);
      ap2(8'h48, 1, 0, 7'd0, 32'h20080005, 0, 16'd1);
      ap2(8'h09, 1, 0, 7'd0, 32'h20080005, 0, 16'd1);
      ap2(8'h01, 0, 1, 7'd1, 32'h01094820, 1, 16'd2);
      // reset mid-header, then N=1
      rs_v();
      ap(0, 1, 8'h05, z());
      ap(1, 1, 8'h77, z());
      ap(0, 1, 8'h01, z());
      ap(0, 1, 8'h00, z());
      ap(0, 1, 8'h78, z());
      ap(0, 1, 8'h56, z());
      ap(0, 1, 8'h34, z());
      ap(0, 1, 8'h12, ex(0, 1, 7'd0, 32'h12345678, 0, 1, 0, 16'd1));
      ap(0, 0, 8'h00, ex(0, 0, 7'd0, 32'h12345678, 1, 1, 0, 16'd1));
      // reset mid-word of an N=3 load, then N=1 0xDEADBEEF
      rs_v();
      ap(0, 1, 8'h03, z());
      ap(0, 1, 8'h00, z());
      ap(0, 1, 8'h11, z());
      ap(0, 1, 8'h22, z());
      ap(0, 1, 8'h33, z());
      ap(0, 1, 8'h44, ex(1, 1, 7'd0, 32'h44332211, 0, 0, 0, 16'd1));
      ap(0, 1, 8'h55, ex(1, 0, 7'd0, 32'h44332211, 0, 0, 0, 16'd1));
      ap(0, 1, 8'h66, ex(1, 0, 7'd0, 32'h44332211, 0, 0, 0, 16'd1));
      ap(1, 1, 8'h77, z());
      ap(0, 1, 8'h01, z());
      ap(0, 1, 8'h00, z());
      ap(0, 1, 8'hEF, z());
      ap(0, 1, 8'hBE, z());
      ap(0, 1, 8'hAD, z());
      ap(0, 1, 8'hDE, ex(0, 1, 7'd0, 32'hDEADBEEF, 0, 1, 0, 16'd1));
      ap(0, 1, 8'h99, ex(0, 0, 7'd0, 32'hDEADBEEF, 1, 1, 0, 16'd1));
      // N=0 goes straight to done
      rs_v();
      ap(0, 1, 8'h00, z());
      ap(0, 1, 8'h00, ex(0, 0, 7'd0, 32'h0, 0, 1, 0, 16'd0));
      ap(0, 1, 8'h05, ex(0, 0, 7'd0, 32'h0, 1, 1, 0, 16'd0));
`else
      // checksum match: 1 + 2 = 3
      for (int pass = 0; pass < 2; pass++) begin
         rs_v();
         ap(0, 1, 8'h02, z());
         ap(0, 1, 8'h00, z());
         ap(0, 1, 8'h01, z());
         ap(0, 1, 8'h00, z());
         ap(0, 1, 8'h00, z());
         ap(0, 1, 8'h00, ex(1, 1, 7'd0, 32'h1, 0, 0, 0, 16'd1));
         ap(0, 1, 8'h02, ex(1, 0, 7'd0, 32'h1, 0, 0, 0, 16'd1));
         ap(0, 1, 8'h00, ex(1, 0, 7'd0, 32'h1, 0, 0, 0, 16'd1));
         ap(0, 1, 8'h00, ex(1, 0, 7'd0, 32'h1, 0, 0, 0, 16'd1));
         ap(0, 1, 8'h00, ex(1, 1, 7'd1, 32'h2, 0, 0, 0, 16'd2));
         ap(0, 1, (pass == 0) ? 8'h03 : 8'h04, ex(1, 0, 7'd1, 32'h2, 0, 0, 0, 16'd2));
         ap(0, 1, 8'h00, ex(1, 0, 7'd1, 32'h2, 0, 0, 0, 16'd2));
         ap(0, 1, 8'h00, ex(1, 0, 7'd1, 32'h2, 0, 0, 0, 16'd2));
         if (pass == 0) begin
            ap(0, 1, 8'h00, ex(0, 0, 7'd1, 32'h2, 0, 1, 0, 16'd2));
            ap(0, 1, 8'h55, ex(0, 0, 7'd1, 32'h2, 1, 1, 0, 16'd2));
         end else begin
            ap(0, 1, 8'h00, ex(0, 0, 7'd1, 32'h2, 0, 0, 1, 16'd2));
            ap(0, 1, 8'h55, ex(0, 0, 7'd1, 32'h2, 0, 0, 1, 16'd2));
         end
      end
      // N=0 still requires a zero checksum
      rs_v();
      ap(0, 1, 8'h00, z());
      ap(0, 1, 8'h00, z());
      ap(0, 1, 8'h00, z());
      ap(0, 1, 8'h00, z());
      ap(0, 1, 8'h00, z());
      ap(0, 1, 8'h00, ex(0, 0, 7'd0, 32'h0, 0, 1, 0, 16'd0));
      ap(0, 1, 8'h00, ex(0, 0, 7'd0, 32'h0, 1, 1, 0, 16'd0));
`endif

      foreach (vq[i]) begin
         @(negedge clk);
         rst      = vq[i].r;
         in_valid = vq[i].v;
         in_data  = vq[i].d;
         @(posedge clk);
         #1;
         chk($sformatf("vec%0d", i),
             {4'h0, in_ready, im_we, im_addr, im_wdata, cpu_rstn, done, err, words_loaded},
             {4'h0, vq[i].e});
      end

      // random-gap stream of three words
      hw[0] = 32'hA1B2C3D4;
      hw[1] = 32'h00000000;
      hw[2] = 32'hFFFFFFFF;
      hs.push_back(8'h03);
      hs.push_back(8'h00);
      for (int w = 0; w < 3; w++)
         for (int b = 0; b < 4; b++)
            hs.push_back(hw[w][8*b +: 8]);
`ifdef LOADER_CHECKSUM_EN
      hs.push_back(8'hD3);
      hs.push_back(8'hC3);
      hs.push_back(8'hB2);
      hs.push_back(8'hA1);
`endif
      @(negedge clk);
      rst      = 1'b1;
      in_valid = 1'b0;
      @(negedge clk);
      rst      = 1'b0;
      idx      = 0;
      nw       = 0;
      got_done = 1'b0;
      for (int cyc = 0; cyc < 400 && !got_done; cyc++) begin
         if (cyc > 0) @(negedge clk);
         in_valid = (idx < hs.size()) ? 1'($urandom_range(0, 1)) : 1'b0;
         in_data  = (idx < hs.size()) ? hs[idx] : 8'h00;
         acc      = in_valid && in_ready;
         @(posedge clk);
         #1;
         if (acc) idx++;
         if (im_we) begin
            if (nw < 3) begin
               chk($sformatf("gap_addr%0d", nw), 64'(im_addr), 64'(nw));
               chk($sformatf("gap_data%0d", nw), 64'(im_wdata), 64'(hw[nw]));
            end
            nw++;
         end
         got_done = done;
      end
      chk("gap_done", 64'(got_done), 64'd1);
      chk("gap_nwrites", 64'(nw), 64'd3);
      chk("gap_words_loaded", 64'(words_loaded), 64'd3);
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 8'h42;
      @(posedge clk);
      #1;
      chk("gap_cpu_rstn", 64'({cpu_rstn, in_ready, im_we}), 64'b100);

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
      $finish;
   end

endmodule
